// File: rtl/binary_mul_pkg.sv
// Shared helpers for the pipelined multiplier: width helpers, operand
// conditioning (magnitude and sign flag) and the per-stage control token.
package binary_mul_pkg;

  // Widest operand the conditioning helper handles.
  localparam int unsigned MAX_W = 64;

  // Control part of a token. It travels alongside the magnitude and accumulator fields.
  typedef struct packed {
    logic valid;
    logic tc;
    logic neg;
  } tok_ctl_t;

  // Product width for a given operand width.
  function automatic int unsigned prod_w(input int unsigned w);
    return 2 * w;
  endfunction

  // Multiplier bits consumed by each stage.
  function automatic int unsigned chunk_w(input int unsigned w, input int unsigned s);
    return w / s;
  endfunction

  // Unsigned magnitude of the low w bits of x. The most negative value maps to
  // 2^(w-1), which still fits in w unsigned bits.
  function automatic logic [MAX_W-1:0] mag_of(input logic [MAX_W-1:0] x,
                                              input int unsigned w,
                                              input logic tc);
    logic [MAX_W-1:0] mask;
    mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    if (tc && x[w-1]) return (~x + MAX_W'(1)) & mask;
    else              return x & mask;
  endfunction

  // Sign of the product. It is set only when the operands are signed and their signs differ.
  function automatic logic neg_of(input logic a_msb, input logic b_msb, input logic tc);
    return tc & (a_msb ^ b_msb);
  endfunction

endpackage

// File: rtl/binary_mul_pipe_stage.sv
// One registered accumulate step of the multiplier pipe. Stage IDX adds
// |A| times its CH-bit slice of |B|. The first stage also conditions the raw
// operands. The last stage applies the sign and holds its output through bubbles.
module binary_mul_pipe_stage
  import binary_mul_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4,
  parameter int unsigned IDX    = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  tok_ctl_t           in_ctl,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [2*WIDTH-1:0] in_acc,
  output tok_ctl_t           out_ctl,
  output logic [WIDTH-1:0]   out_a,
  output logic [WIDTH-1:0]   out_b,
  output logic [2*WIDTH-1:0] out_acc
);

  localparam int unsigned PW    = prod_w(WIDTH);
  localparam int unsigned CH    = chunk_w(WIDTH, STAGES);
  localparam bit          FIRST = (IDX == 0);
  localparam bit          LAST  = (IDX == STAGES - 1);

  tok_ctl_t         ctl_d, ctl_q;
  logic [WIDTH-1:0] a_d, a_q, b_d, b_q;
  logic [PW-1:0]    acc_d, acc_q;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic             neg;
  logic [CH-1:0]    b_slice;
  logic [PW-1:0]    partial, sum, result;

  // Condition operands in the first stage, add this stage's partial product,
  // and negate in the last stage.
  always_comb begin
    a_mag   = FIRST ? WIDTH'(mag_of(MAX_W'(in_a), WIDTH, in_ctl.tc)) : in_a;
    b_mag   = FIRST ? WIDTH'(mag_of(MAX_W'(in_b), WIDTH, in_ctl.tc)) : in_b;
    neg     = in_ctl.neg | (FIRST & neg_of(in_a[WIDTH-1], in_b[WIDTH-1], in_ctl.tc));
    b_slice = b_mag[IDX*CH +: CH];
    partial = (PW'(a_mag) * PW'(b_slice)) << (IDX * CH);
    sum     = in_acc + partial;
    // A zero magnitude negates to zero, so no negative zero can appear.
    result  = (LAST && neg) ? -sum : sum;

    ctl_d = ctl_q;
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    if (en) begin
      ctl_d = '{valid: in_ctl.valid, tc: in_ctl.tc, neg: neg};
      a_d   = a_mag;
      b_d   = b_mag;
      // The last stage's accumulator is the visible product. Bubbles leave it untouched.
      if (in_ctl.valid || !LAST) acc_d = result;
    end
  end

  // Stage register with synchronous clear. Reset takes priority over en.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctl_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      ctl_q <= ctl_d;
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign out_ctl = ctl_q;
  assign out_a   = a_q;
  assign out_b   = b_q;
  assign out_acc = acc_q;

endmodule

// File: rtl/binary_mul_pipe.sv
// Streaming WIDTH x WIDTH multiplier with STAGES cycles of latency. It accepts
// one token per enabled cycle and selects unsigned or signed mode per token.
// Handshake: in_valid qualifies A/B/tc on an enabled edge. out_valid marks the
// single cycle in which a new product is on P. There is no backpressure, and
// en=0 freezes the whole pipe.
module binary_mul_pipe
  import binary_mul_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               in_valid,
  input  logic               tc,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] P
);

  localparam int unsigned PW = prod_w(WIDTH);

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("binary_mul_pipe: need WIDTH >= 2, 1 <= STAGES <= WIDTH, WIDTH %% STAGES == 0");
  end

  // Index 0 is the port side. Index i is the output of stage i.
  tok_ctl_t         ctl   [STAGES+1];
  logic [WIDTH-1:0] a_s   [STAGES+1];
  logic [WIDTH-1:0] b_s   [STAGES+1];
  logic [PW-1:0]    acc_s [STAGES+1];

  assign ctl[0]   = '{valid: in_valid, tc: tc, neg: 1'b0};
  assign a_s[0]   = A;
  assign b_s[0]   = B;
  assign acc_s[0] = '0;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    binary_mul_pipe_stage #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES),
      .IDX    (i)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .in_ctl  (ctl[i]),
      .in_a    (a_s[i]),
      .in_b    (b_s[i]),
      .in_acc  (acc_s[i]),
      .out_ctl (ctl[i+1]),
      .out_a   (a_s[i+1]),
      .out_b   (b_s[i+1]),
      .out_acc (acc_s[i+1])
    );
  end

  assign out_valid = ctl[STAGES].valid;
  assign P         = acc_s[STAGES];

endmodule

// File: tb/tb_binary_mul_pipe.sv
// Bench for binary_mul_pipe: directed vector table and hand-written
// stall/bubble/reset sequences on a 16x16, 4-stage instance, and a golden-model
// sweep of three 8-bit instances with 1, 2 and 8 stages.
module tb_binary_mul_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, in_valid, tc;
  logic [15:0] A, B;
  logic        out_valid;
  logic [31:0] P;

  binary_mul_pipe #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .tc(tc),
    .A(A), .B(B), .out_valid(out_valid), .P(P)
  );

  logic        sw_valid, sw_tc;
  logic [7:0]  sw_a, sw_b;
  logic        o1_v, o2_v, o8_v;
  logic [15:0] o1_p, o2_p, o8_p;

  binary_mul_pipe #(.WIDTH(8), .STAGES(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .in_valid(sw_valid), .tc(sw_tc),
    .A(sw_a), .B(sw_b), .out_valid(o1_v), .P(o1_p)
  );
  binary_mul_pipe #(.WIDTH(8), .STAGES(2)) dut_s2 (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .in_valid(sw_valid), .tc(sw_tc),
    .A(sw_a), .B(sw_b), .out_valid(o2_v), .P(o2_p)
  );
  binary_mul_pipe #(.WIDTH(8), .STAGES(8)) dut_s8 (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .in_valid(sw_valid), .tc(sw_tc),
    .A(sw_a), .B(sw_b), .out_valid(o8_v), .P(o8_p)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;

  // Latency model of the 4-stage pipe: expected tokens by stage position.
  logic        m_v [1:4];
  logic [31:0] m_p [1:4];
  logic [31:0] hold_p;

  logic [15:0] exp_q1[$];
  logic [15:0] exp_q2[$];
  logic [15:0] exp_q8[$];

  typedef struct {
    logic        tc;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;
  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s got=output exp=no-output", name);
  endtask

  // Signed or unsigned product of w-bit operands. Computed in 64-bit signed arithmetic.
  function automatic logic [31:0] gold(input logic [15:0] a, input logic [15:0] b,
                                       input int w, input logic t);
    longint sa, sb, p;
    sa = longint'(a);
    sb = longint'(b);
    if (t && a[w-1]) sa = sa - (longint'(1) << w);
    if (t && b[w-1]) sb = sb - (longint'(1) << w);
    p = sa * sb;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  // ---------------- driver tasks ----------------
  // Drive one cycle on the 4-stage DUT, advance the model, then check both outputs.
  task automatic cyc(input logic e, input logic r, input logic v, input logic t,
                     input logic [15:0] a, input logic [15:0] b, input logic [31:0] ex);
    en = e; rst_n = r; in_valid = v; tc = t; A = a; B = b;
    if (!r) begin
      for (int i = 1; i <= 4; i++) begin
        m_v[i] = 1'b0;
        m_p[i] = '0;
      end
      hold_p = '0;
    end else if (e) begin
      for (int i = 4; i > 1; i--) begin
        m_v[i] = m_v[i-1];
        m_p[i] = m_p[i-1];
      end
      m_v[1] = v;
      m_p[1] = ex;
      if (m_v[4]) hold_p = m_p[4];
    end
    @(posedge clk);
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, m_v[4]});
    check("P", P, hold_p);
  endtask

  task automatic sweep_check(input logic v);
    check("s1_latency", {31'd0, o1_v}, {31'd0, v});
    if (o1_v) begin
      if (exp_q1.size() == 0) fail_now("s1_extra");
      else check("s1_p", {16'd0, o1_p}, {16'd0, exp_q1.pop_front()});
    end
    if (o2_v) begin
      if (exp_q2.size() == 0) fail_now("s2_extra");
      else check("s2_p", {16'd0, o2_p}, {16'd0, exp_q2.pop_front()});
    end
    if (o8_v) begin
      if (exp_q8.size() == 0) fail_now("s8_extra");
      else check("s8_p", {16'd0, o8_p}, {16'd0, exp_q8.pop_front()});
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] corners[6];
    logic [7:0] sb;
    logic       sv;

    corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'h81, 8'hFF};

    rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; tc = 1'b0; A = '0; B = '0;
    sw_valid = 1'b0; sw_tc = 1'b0; sw_a = '0; sw_b = '0;
    for (int i = 1; i <= 4; i++) begin
      m_v[i] = 1'b0;
      m_p[i] = '0;
    end
    hold_p = '0;

    vecs[0]  = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    vecs[1]  = '{1'b0, 16'hFFFF, 16'h0001, 32'h0000FFFF};
    vecs[2]  = '{1'b1, 16'h8000, 16'h8000, 32'h40000000};
    vecs[3]  = '{1'b1, 16'hFFFF, 16'h0001, 32'hFFFFFFFF};
    vecs[4]  = '{1'b1, 16'h8000, 16'h0000, 32'h00000000};
    vecs[5]  = '{1'b0, 16'h0003, 16'h0005, 32'h0000000F};
    vecs[6]  = '{1'b1, 16'hFFFD, 16'h0005, 32'hFFFFFFF1};
    vecs[7]  = '{1'b0, 16'h0007, 16'hFFFF, 32'h0006FFF9};
    vecs[8]  = '{1'b1, 16'h7FFF, 16'h8000, 32'hC0008000};
    vecs[9]  = '{1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001};
    vecs[10] = '{1'b0, 16'h1234, 16'h0010, 32'h00012340};
    vecs[11] = '{1'b1, 16'h0000, 16'hFFFF, 32'h00000000};
    vecs[12] = '{1'b0, 16'h8000, 16'h8000, 32'h40000000};
    vecs[13] = '{1'b1, 16'h7FFF, 16'h7FFF, 32'h3FFF0001};

    // Reset state.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 32'h0);

    // Table vectors streamed back to back, then drained.
    for (int i = 0; i < 14; i++)
      cyc(1'b1, 1'b1, 1'b1, vecs[i].tc, vecs[i].a, vecs[i].b, vecs[i].p);
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 32'h0);

    // Stall mid-flight with bubbles. Inputs offered while en=0 must be ignored.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h00AB, 16'h0101, 32'h0000ABAB);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 32'h0);
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'hDEAD, 16'hBEEF, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFE, 16'h0003, 32'hFFFFFFFA);
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 32'h0);

    // Reset with three tokens in flight and en=0. Reset wins, and nothing stale comes out.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0002, 16'h0003, 32'h00000006);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0100, 16'h0100, 32'h00010000);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 16'h0005, 16'h0005, 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0009, 16'h0009, 32'h00000051);
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 32'h0);

    // Sweep of the 8-bit instances against the golden model.
    en = 1'b0; in_valid = 1'b0;
    for (int a = 0; a < 256; a++) begin
      for (int k = 0; k < 10; k++) begin
        for (int t = 0; t < 2; t++) begin
          sb = (k < 6) ? corners[k] : 8'($urandom_range(0, 255));
          sv = ($urandom_range(0, 9) != 0);
          sw_valid = sv; sw_tc = 1'(t); sw_a = 8'(a); sw_b = sb;
          if (sv) begin
            exp_q1.push_back(16'(gold({8'd0, sw_a}, {8'd0, sb}, 8, sw_tc)));
            exp_q2.push_back(16'(gold({8'd0, sw_a}, {8'd0, sb}, 8, sw_tc)));
            exp_q8.push_back(16'(gold({8'd0, sw_a}, {8'd0, sb}, 8, sw_tc)));
          end
          @(posedge clk);
          #1;
          sweep_check(sv);
        end
      end
    end
    sw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      sweep_check(1'b0);
    end
    check("s1_drain", exp_q1.size(), 0);
    check("s2_drain", exp_q2.size(), 0);
    check("s8_drain", exp_q8.size(), 0);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
